edgetracing_accel_addr_gen: RTL and testbench
=============================================

Name: edgetracing_accel_addr_gen

Overview:
- Issue/collect stage wrapped around the 12s x 6ns -> 18 DSP multiplier in the edge-tracing accelerator.
- Accepts neighbour-offset requests (signed offset, unsigned stride, base address) on a valid/ready port and drives the multiplier's din0/din1/ce.
- Tracks in-flight products with a valid shift register and forms addr = base + sext(product).
- Buffers results in a small FIFO toward the edge-tracing memory port; back-pressure freezes the multiplier through ce.

Parameters:
- MUL_LAT, 3, number of ce-qualified clk edges from mul_din0/din1 to mul_dout; must match the multiplier instance.
- ADDR_W, 20, width of base and output address (>= 18).
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_offset  in  12  signed neighbour offset, goes to mul_din0
- in_stride  in  6  unsigned row stride, goes to mul_din1
- in_base  in  ADDR_W  base address added to the product
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  12  = in_offset (combinational pass-through)
- mul_din1  out  6  = in_stride (combinational pass-through)
- mul_dout  in  18  signed product from the multiplier
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_addr  out  ADDR_W  FIFO head: base + sext(product), modulo 2^ADDR_W
- busy  out  1  any in-flight product or FIFO entry

Behaviour:
- Reset (async assert, sync release):
  - vld_sr = 0, base_sr = 0, FIFO empty, pointers 0.
  - out_valid = 0, out_addr = 0, busy = 0.
  - mul_ce = 1 and in_ready = 1, because the pipe is empty.
- Land condition: land = mul_ce & vld_sr[MUL_LAT-1].
- Stall: mul_ce = !(land_pending & fifo_full & !out_ready), where land_pending = vld_sr[MUL_LAT-1].
  - Combinational from out_ready; FIFO depth therefore never needs credit slack.
- in_ready = mul_ce. Accept = in_valid & in_ready.
- When mul_ce = 1, every clk edge:
  - vld_sr shifts in accept.
  - base_sr shifts in in_base, with the same depth MUL_LAT as vld_sr.
  - If mul_ce = 0, vld_sr and base_sr hold, in lockstep with the frozen multiplier.
- Bubbles: a request with in_valid = 0 inserts vld 0, but the multiplier still clocks garbage. Garbage is never written to the FIFO.
- On land, write base_sr[MUL_LAT-1] + sext(mul_dout to ADDR_W) to the FIFO. Overflow wraps silently; there is no flag.
- Latency: accept at edge t, land at edge t+MUL_LAT, out_valid high from that edge. Minimum 3 cycles request-to-out_valid with no stalls.
- Throughput: one result per cycle when out_ready is held high.
- FIFO behaviour:
  - Simultaneous push and pop when full: allowed, count unchanged.
  - Push when empty: out_valid rises next cycle. There is no fall-through.
  - Pop when empty: ignored.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; an extra count register gives full/empty.
- out_addr is registered from the FIFO head and stable while out_valid & !out_ready.
- busy = |vld_sr | !fifo_empty.
- Reset mid-operation: all in-flight and buffered results are discarded. No partial output after release.

Optional Feature:
- Macro: EDGETRACING_ADDR_GEN_STATS_EN.
- Defined: adds ports stat_out_cnt (32 b, results popped) and stat_stall_cnt (32 b, cycles with mul_ce = 0).
  - Both are cleared by reset, saturate at all-ones, and hold when disabled.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package edgetracing_accel_pkg holds:
  - MUL_A_W = 12, MUL_B_W = 6, MUL_P_W = 18, MUL_LAT_DEFAULT = 3.
  - Address typedef addr_t (ADDR_W bits).
  - Function sext_prod(18 -> ADDR_W).
- One natural sub-module: edgetracing_accel_addr_fifo, a synchronous FIFO with registered head output, count and full/empty.
- The shift-register tracker stays inline.

Test Plan:
- Single request: offset = -3, stride = 40, base = 1000 -> out_addr = 880, out_valid asserted 3 cycles after accept; busy falls after pop.
- Back-to-back: 8 requests, offset = i-4, stride = 63, base = 0x100, out_ready = 1 -> 8 consecutive results 0x100 + 63*(i-4), one per cycle, no stall.
- Back-pressure: out_ready = 0 while 7 requests are sent.
  - After 4 land, mul_ce = 0 and in_ready = 0, with vld_sr frozen and holding 3.
  - Releasing out_ready drains all 7 in order with no loss or duplicate.
- Full and simultaneous: FIFO full, land pending, out_ready = 1 -> mul_ce stays 1, count stays 4, order preserved.
- Wrap: base = 0x00010, offset = -2048, stride = 63 -> out_addr = (0x10 - 129024) mod 2^20 = 0xE0810.
- Async reset asserted with 2 in flight and 3 buffered -> out_valid = 0 immediately. After release, nothing emerges until a new accept. With STATS_EN, counters read 0.

Source files
------------

// File: rtl/edgetracing_accel_pkg.sv
// Shared constants, address type and product sign-extension for the edge-tracing accelerator.
// Multiplier geometry must match the DSP instance wired to the address generator.
package edgetracing_accel_pkg;

  localparam int unsigned MUL_A_W         = 12;
  localparam int unsigned MUL_B_W         = 6;
  localparam int unsigned MUL_P_W         = 18;
  localparam int unsigned MUL_LAT_DEFAULT = 3;
  localparam int unsigned ADDR_W_DEFAULT  = 20;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

  function automatic addr_t sext_prod(input logic [MUL_P_W-1:0] prod);
    return {{(ADDR_W_DEFAULT - MUL_P_W){prod[MUL_P_W-1]}}, prod};
  endfunction

endpackage

// File: rtl/edgetracing_accel_addr_gen_if.sv
// Request, multiplier and result signals of the address generator, bundled as one interface.
// slave: the address generator itself; master: the surrounding tracer/multiplier environment.
interface edgetracing_accel_addr_gen_if
  import edgetracing_accel_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [MUL_A_W-1:0] in_offset;
  logic [MUL_B_W-1:0] in_stride;
  logic [ADDR_W-1:0]  in_base;
  logic               mul_ce;
  logic [MUL_A_W-1:0] mul_din0;
  logic [MUL_B_W-1:0] mul_din1;
  logic [MUL_P_W-1:0] mul_dout;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic               busy;

  modport slave (
    input  in_valid, in_offset, in_stride, in_base, mul_dout, out_ready,
    output in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_addr, busy
  );

  modport master (
    output in_valid, in_offset, in_stride, in_base, mul_dout, out_ready,
    input  in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_addr, busy
  );

endinterface

// File: rtl/edgetracing_accel_addr_fifo.sv
// Synchronous result FIFO with a registered head output (no fall-through) and occupancy count.
// A push is accepted while full only when a pop happens on the same edge.
module edgetracing_accel_addr_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned   PtrW    = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);
  localparam logic [PtrW:0] CntOne  = (PtrW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntFull);
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
  assign rdata      = head_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Head is preloaded so out_addr comes straight from a flop.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q > CntOne) begin
        head_d = mem_q[rd_ptr_nxt];
      end else if (do_push) begin
        head_d = wdata;
      end
    end else if (do_push && empty) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/edgetracing_accel_addr_gen.sv
// Issue/collect stage around the offset x stride multiplier; forms base + sext(product) addresses.
// Optional counters behind EDGETRACING_ADDR_GEN_STATS_EN (results popped, stalled cycles).
module edgetracing_accel_addr_gen
  import edgetracing_accel_pkg::*;
#(
  parameter int unsigned MUL_LAT    = MUL_LAT_DEFAULT,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  edgetracing_accel_addr_gen_if.slave  bus
`ifdef EDGETRACING_ADDR_GEN_STATS_EN
  ,
  output logic [31:0]                  stat_out_cnt,
  output logic [31:0]                  stat_stall_cnt
`endif
);

  logic [MUL_LAT-1:0] vld_sr_q;
  logic [ADDR_W-1:0]  base_sr_q [MUL_LAT];
  logic [ADDR_W-1:0]  prod_sext;
  logic [ADDR_W-1:0]  land_addr;
  logic               land_pending, land, accept, mul_ce;
  logic               fifo_full, fifo_empty;

  // Stall only when a landing product has nowhere to go this edge.
  assign land_pending = vld_sr_q[MUL_LAT-1];
  assign mul_ce       = ~(land_pending & fifo_full & ~bus.out_ready);
  assign land         = mul_ce & land_pending;
  assign accept       = bus.in_valid & mul_ce;

  assign bus.in_ready = mul_ce;
  assign bus.mul_ce   = mul_ce;
  assign bus.mul_din0 = bus.in_offset;
  assign bus.mul_din1 = bus.in_stride;
  assign bus.busy     = (|vld_sr_q) | ~fifo_empty;
  assign bus.out_valid = ~fifo_empty;

  if (ADDR_W == ADDR_W_DEFAULT) begin : g_sext_pkg
    assign prod_sext = sext_prod(bus.mul_dout);
  end else begin : g_sext_gen
    assign prod_sext = ADDR_W'($signed(bus.mul_dout));
  end

  assign land_addr = base_sr_q[MUL_LAT-1] + prod_sext;

  // Tracker advances in lockstep with the multiplier pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr_q <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) base_sr_q[i] <= '0;
    end else if (mul_ce) begin
      vld_sr_q[0]  <= accept;
      base_sr_q[0] <= bus.in_base;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        base_sr_q[i] <= base_sr_q[i-1];
      end
    end
  end

  edgetracing_accel_addr_fifo #(
    .Width (ADDR_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (land),
    .wdata (land_addr),
    .pop   (bus.out_ready),
    .rdata (bus.out_addr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef EDGETRACING_ADDR_GEN_STATS_EN
  logic [31:0] out_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (~fifo_empty && bus.out_ready && (out_cnt_q != '1)) out_cnt_q <= out_cnt_q + 32'd1;
      if (~mul_ce && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_out_cnt   = out_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_edgetracing_accel_addr_gen.sv
// Bench for edgetracing_accel_addr_gen: behavioural 3-stage multiplier, scoreboard of expected
// addresses pushed on accept and compared on pop, plus table vectors and stall/reset sequences.
module tb_edgetracing_accel_addr_gen;

  localparam int unsigned ADDR_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  edgetracing_accel_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef EDGETRACING_ADDR_GEN_STATS_EN
  logic [31:0] stat_out_cnt, stat_stall_cnt;
`endif

  edgetracing_accel_addr_gen #(
    .MUL_LAT    (3),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
`ifdef EDGETRACING_ADDR_GEN_STATS_EN
    ,
    .stat_out_cnt   (stat_out_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: signed 12b x unsigned 6b, three ce-qualified stages.
  int          mul_prod;
  logic [17:0] p_q [3];
  always_comb mul_prod = int'($signed(bus.mul_din0)) * int'({1'b0, bus.mul_din1});
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      p_q[0] <= mul_prod[17:0];
      p_q[1] <= p_q[0];
      p_q[2] <= p_q[1];
    end
  end
  assign bus.mul_dout = p_q[2];

  int n_vec = 0;
  int n_err = 0;
  int stalls = 0;
  int pop_run = 0;
  int max_run = 0;
  logic [ADDR_W-1:0] cur_exp;
  logic [ADDR_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] model(input int off, input int stride, input int base);
    int r;
    r = base + off * stride;
    return r[ADDR_W-1:0];
  endfunction

  // Scoreboard: sample just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
        if (bus.out_valid && bus.out_ready) begin
          check("output_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("out_addr", 32'(bus.out_addr), 32'(exp_q.pop_front()));
          pop_run++;
          if (pop_run > max_run) max_run = pop_run;
        end else begin
          pop_run = 0;
        end
      end
    end
  end

  task automatic send(input int off, input int stride, input int base, input logic [ADDR_W-1:0] e);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_offset = off[11:0];
    bus.in_stride = stride[5:0];
    bus.in_base   = base[ADDR_W-1:0];
    cur_exp       = e;
    #1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
      stalls++;
    end
    if (guard == 100) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
  endtask

  typedef struct {
    int                off;
    int                stride;
    int                base;
    logic [ADDR_W-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int stuck;

    tbl[0] = '{off: -3,    stride: 40, base: 1000,      exp: 20'd880};
    tbl[1] = '{off: -2048, stride: 63, base: 'h00010,   exp: 20'hE0810};
    tbl[2] = '{off: 2047,  stride: 63, base: 0,         exp: 20'h1F7C1};
    tbl[3] = '{off: 0,     stride: 63, base: 'hFFFFF,   exp: 20'hFFFFF};
    tbl[4] = '{off: 1,     stride: 1,  base: 'hFFFFF,   exp: 20'h00000};
    tbl[5] = '{off: -1,    stride: 1,  base: 0,         exp: 20'hFFFFF};
    tbl[6] = '{off: 100,   stride: 0,  base: 'h12345,   exp: 20'h12345};
    tbl[7] = '{off: -2048, stride: 0,  base: 5,         exp: 20'h00005};
    tbl[8] = '{off: 7,     stride: 10, base: 'h400,     exp: 20'h00446};
    tbl[9] = '{off: -100,  stride: 50, base: 'h8000,    exp: 20'h06C78};

    bus.in_valid  = 1'b0;
    bus.in_offset = '0;
    bus.in_stride = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_ce", 32'(bus.mul_ce), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Single request: latency 3, then pop clears busy.
    send(-3, 40, 1000, 20'd880);
    idle();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("single_latency", 32'(lat), 32'd3);
    check("single_addr", 32'(bus.out_addr), 32'd880);
    check("single_busy", 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("single_valid_after_pop", 32'(bus.out_valid), 32'd0);
    check("single_busy_after_pop", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].off, tbl[i].stride, tbl[i].base, tbl[i].exp);
    end
    idle();
    wait_drain();

    // Back-to-back with out_ready high: no stall, eight consecutive results.
    stalls  = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) send(i - 4, 63, 'h100, model(i - 4, 63, 'h100));
    idle();
    wait_drain();
    check("b2b_stalls", 32'(stalls), 32'd0);
    check("b2b_run", 32'(max_run), 32'd8);

    // Back-pressure: 4 land, 3 frozen in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(i * 3 - 9, 17 + i, 'h2000 + i * 16, model(i * 3 - 9, 17 + i, 'h2000 + i * 16));
    end
    idle();
    #1;
    check("bp_mul_ce", 32'(bus.mul_ce), 32'd0);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_busy", 32'(bus.busy), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_offset = 12'd1;
    bus.in_stride = 6'd1;
    bus.in_base   = 20'h55555;
    cur_exp       = 20'h55556;
    stuck = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (!bus.mul_ce && !bus.in_ready) stuck++;
    end
    check("bp_hold_cycles", 32'(stuck), 32'd3);
    bus.in_valid = 1'b0;

    // Full with a land pending and out_ready high: push and pop together.
    bus.out_ready = 1'b1;
    #1;
    check("full_simul_mul_ce", 32'(bus.mul_ce), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("full_simul_still_full", 32'(bus.mul_ce), 32'd0);
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset with 2 in flight and 3 buffered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i + 1, 9, 'h700, model(i + 1, 9, 'h700));
    idle();
    @(negedge clk);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_mul_ce", 32'(bus.mul_ce), 32'd1);
    check("mid_rst_out_addr", 32'(bus.out_addr), 32'd0);
`ifdef EDGETRACING_ADDR_GEN_STATS_EN
    check("mid_rst_stat_out", stat_out_cnt, 32'd0);
    check("mid_rst_stat_stall", stat_stall_cnt, 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    send(5, 5, 'h300, 20'h319);
    idle();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
